rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the number of registers in the register file.
REQ-002 The block SHALL have parameter BITS, default 64, giving the data width; AW = $clog2(DEPTH) is the derived address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req0_valid / req0_addr / req0_data, input, 1 / AW / BITS bits: write-back request from the ALU.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: req0 accepted this cycle.
REQ-007 The block SHALL have port req1_valid / req1_addr / req1_data, input, 1 / AW / BITS bits: write-back request from the load unit.
REQ-008 The block SHALL have port req1_ready, output, 1 bit: req1 accepted this cycle.
REQ-009 The block SHALL have port rsv_valid / rsv_addr, input, 1 / AW bits: the issue stage reserves a destination register.
REQ-010 The block SHALL have port rf_writeEn / rf_addressw / rf_writeData, output, 1 / AW / BITS bits: the register-file write port.
REQ-011 The block SHALL have port busy, output, DEPTH bits: scoreboard, where bit i = 1 means a write to register i is pending.

Function
REQ-012 A transfer on requester n SHALL occur when reqn_valid and reqn_ready are both 1 at a rising edge; reqn_ready is combinational from the valids, the addresses and the priority register, and never depends on rf outputs.
REQ-013 A request whose address is 0 SHALL be accepted immediately (ready = 1) regardless of the other requester, SHALL never drive the write port, and SHALL NOT change the priority register.
REQ-014 Among requests with nonzero address, at most one SHALL be granted per cycle; a lone valid request is always granted.
REQ-015 On conflict, the grant SHALL go to the requester not granted most recently: a 1-bit last_grant register, updated only on a nonzero-address grant.
REQ-016 A nonzero-address grant in cycle N SHALL produce rf_writeEn = 1 with the granted addr/data on rf_addressw/rf_writeData during cycle N+1 only; the output stage is registered, with latency 1.
REQ-017 When there is no nonzero grant in cycle N, rf_writeEn SHALL be 0 in cycle N+1, and rf_addressw/rf_writeData SHALL hold their previous values.
REQ-018 A non-granted requester SHALL keep valid, addr and data stable until accepted; the block does not buffer losing requests.
REQ-019 rsv_valid = 1 with rsv_addr != 0 SHALL set busy[rsv_addr] at the next edge.
REQ-020 A nonzero-address grant SHALL clear busy[granted addr] at the next edge.
REQ-021 If a reserve and a grant hit the same address in the same cycle, the reserve SHALL win and busy stays 1.
REQ-022 A reserve of an already-busy register SHALL leave it at 1, and a grant to a non-busy register SHALL leave it at 0; neither is an error.
REQ-023 busy[0] SHALL be constant 0; a reserve of address 0 SHALL be ignored.
REQ-024 A reserve and a grant to different addresses in the same cycle SHALL both take effect.

Reset
REQ-025 While rst = 1 at a rising edge: busy SHALL be 0 for all bits, rf_writeEn 0, rf_addressw 0, rf_writeData 0, and last_grant = 1 (so req0 wins the first conflict).
REQ-026 While rst = 1, req0_ready and req1_ready SHALL be 0, and reserves and grants in that cycle SHALL be discarded.
REQ-027 A reset asserted in the cycle after a grant SHALL suppress that grant's pending rf_writeEn; the lost write is the system's responsibility.

Verification
REQ-028 Reset, then idle: busy = 0, rf_writeEn = 0, both ready = 0 during rst and both ready = 0 after it with no valid.
REQ-029 req0 alone, addr 5, data 0xAA: req0_ready = 1 in cycle N; in cycle N+1 rf_writeEn = 1, rf_addressw = 5, rf_writeData = 0xAA; rf_writeEn = 0 in N+2.
REQ-030 Both valid (addr 3 and addr 7) for 3 cycles after reset: grants SHALL go req0, req1, req0; write port addresses SHALL be 3, 7, 3 in the following cycles.
REQ-031 req0 addr 0 and req1 addr 9 together: both ready = 1; only addr 9 written; last_grant becomes req1.
REQ-032 rsv 4 in cycle N gives busy[4] = 1 in N+1; grant to addr 4 alongside a new rsv 4 keeps busy[4] = 1; a later lone grant to 4 clears it; rsv 0 leaves busy = 0.
REQ-033 Assert rst the cycle after a grant to addr 6 with busy[6] = 1: no write in that cycle, and busy = 0 afterwards.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester write-back arbiter for a register file.
// req0 (ALU) and req1 (load unit) compete for the single write port.
// Address 0 is a discard target, so it is accepted without arbitration.
// Nonzero-address conflicts alternate between the requesters.
// The write port is registered with a latency of one cycle.
// A busy scoreboard tracks registers reserved by issue and not yet written.
module rf_write_arbiter #(
  parameter int DEPTH = 32,
  parameter int BITS  = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [AW-1:0]    req0_addr,
  input  logic [BITS-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [AW-1:0]    req1_addr,
  input  logic [BITS-1:0]  req1_data,
  output logic             req1_ready,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rf_writeEn,
  output logic [AW-1:0]    rf_addressw,
  output logic [BITS-1:0]  rf_writeData,
  output logic [DEPTH-1:0] busy
);

  // One-hot decode of a register address into a scoreboard mask.
  function automatic logic [DEPTH-1:0] f_onehot(input logic [AW-1:0] addr);
    logic [DEPTH-1:0] mask;
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // True when a request targets a real register (address 0 is a sink).
  function automatic logic f_real_dst(input logic vld, input logic [AW-1:0] addr);
    return vld && (addr != '0);
  endfunction

  // r_last_grant: 0 = req0 was granted most recently, 1 = req1.
  logic             r_last_grant;
  logic [DEPTH-1:0] r_busy;
  logic             r_wr_vld_p1;
  logic [AW-1:0]    r_wr_addr_p1;
  logic [BITS-1:0]  r_wr_data_p1;

  logic             w_nz0_p0;
  logic             w_nz1_p0;
  logic             w_gnt0_p0;
  logic             w_gnt1_p0;
  logic             w_gnt_vld_p0;
  logic [AW-1:0]    w_gnt_addr_p0;
  logic [BITS-1:0]  w_gnt_data_p0;
  logic             w_rsv_nz_p0;
  logic [DEPTH-1:0] w_clr_mask;
  logic [DEPTH-1:0] w_set_mask;
  logic [DEPTH-1:0] w_busy_nxt;

  // ---- stage p0: arbitration and ready generation (combinational) ----
  // Arbitrate nonzero-address requests; zero-address requests always pass.
  always_comb begin
    w_nz0_p0      = f_real_dst(req0_valid, req0_addr);
    w_nz1_p0      = f_real_dst(req1_valid, req1_addr);
    w_gnt0_p0     = 1'b0;
    w_gnt1_p0     = 1'b0;
    w_gnt_vld_p0  = 1'b0;
    w_gnt_addr_p0 = req0_addr;
    w_gnt_data_p0 = req0_data;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    if (!rst) begin
      // On conflict the requester that did not win last time goes first.
      w_gnt0_p0  = w_nz0_p0 && (!w_nz1_p0 || r_last_grant);
      w_gnt1_p0  = w_nz1_p0 && (!w_nz0_p0 || !r_last_grant);
      req0_ready = req0_valid && (!w_nz0_p0 || w_gnt0_p0);
      req1_ready = req1_valid && (!w_nz1_p0 || w_gnt1_p0);
    end
    w_gnt_vld_p0 = w_gnt0_p0 || w_gnt1_p0;
    if (w_gnt1_p0) begin
      w_gnt_addr_p0 = req1_addr;
      w_gnt_data_p0 = req1_data;
    end
  end

  // Compute next scoreboard: clear the granted register, then apply reserve.
  always_comb begin
    w_rsv_nz_p0 = f_real_dst(rsv_valid, rsv_addr);
    w_clr_mask  = '0;
    w_set_mask  = '0;
    if (w_gnt_vld_p0) w_clr_mask = f_onehot(w_gnt_addr_p0);
    if (w_rsv_nz_p0)  w_set_mask = f_onehot(rsv_addr);
    // Setting after clearing lets a same-cycle reserve win over the grant.
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  // ---- stage p0 -> p1: state registers ----
  // Priority register, moved only by grants that actually write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt0_p0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt1_p0) begin
      r_last_grant <= 1'b1;
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Registered write port; address and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_vld_p1  <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else begin
      r_wr_vld_p1 <= w_gnt_vld_p0;
      if (w_gnt_vld_p0) begin
        r_wr_addr_p1 <= w_gnt_addr_p0;
        r_wr_data_p1 <= w_gnt_data_p0;
      end
    end
  end

  // ---- stage p1: register-file write port ----
  // A reset arriving while a write is pending squashes that write.
  assign rf_writeEn   = r_wr_vld_p1 && !rst;
  assign rf_addressw  = r_wr_addr_p1;
  assign rf_writeData = r_wr_data_p1;
  assign busy         = r_busy;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed per-cycle vector table followed by a
// randomized two-requester phase checked through a write scoreboard queue.
module tb_rf_write_arbiter;
  localparam int DEPTH = 32;
  localparam int BITS  = 64;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic [AW-1:0]    req0_addr = '0;
  logic [BITS-1:0]  req0_data = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [AW-1:0]    req1_addr = '0;
  logic [BITS-1:0]  req1_data = '0;
  logic             req1_ready;
  logic             rsv_valid = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;
  logic             rf_writeEn;
  logic [AW-1:0]    rf_addressw;
  logic [BITS-1:0]  rf_writeData;
  logic [DEPTH-1:0] busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .rf_writeEn(rf_writeEn), .rf_addressw(rf_addressw), .rf_writeData(rf_writeData),
    .busy(busy)
  );

  // One row = one clock cycle: inputs driven in that cycle, the combinational
  // readies expected in it, and the registered outputs visible during it.
  typedef struct {
    logic            rst;
    logic            v0;
    logic [AW-1:0]   a0;
    logic [BITS-1:0] d0;
    logic            v1;
    logic [AW-1:0]   a1;
    logic [BITS-1:0] d1;
    logic            rv;
    logic [AW-1:0]   ra;
    logic            e_r0;
    logic            e_r1;
    logic            e_we;
    logic [AW-1:0]   e_wa;
    logic [BITS-1:0] e_wd;
    logic [DEPTH-1:0] e_busy;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [BITS-1:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];

  function automatic vec_t mk(input logic r, input logic v0, input int a0, input logic [BITS-1:0] d0,
                              input logic v1, input int a1, input logic [BITS-1:0] d1,
                              input logic rv, input int ra, input logic e_r0, input logic e_r1,
                              input logic e_we, input int e_wa, input logic [BITS-1:0] e_wd,
                              input logic [DEPTH-1:0] e_busy);
    vec_t t;
    t.rst = r;  t.v0 = v0; t.a0 = AW'(a0); t.d0 = d0;
    t.v1 = v1;  t.a1 = AW'(a1); t.d1 = d1;
    t.rv = rv;  t.ra = AW'(ra);
    t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_we = e_we;
    t.e_wa = AW'(e_wa); t.e_wd = e_wd; t.e_busy = e_busy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the registered write port against the scoreboard queue head.
  task automatic chk_write_port(input string tag);
    wr_t e;
    chk({tag, "_we"}, 64'(rf_writeEn), 64'(sb.size() != 0));
    if (rf_writeEn && sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_waddr"}, 64'(rf_addressw), 64'(e.a));
      chk({tag, "_wdata"}, 64'(rf_writeData), 64'(e.d));
    end else if (sb.size() != 0) begin
      void'(sb.pop_front());
    end
  endtask

  localparam logic [DEPTH-1:0] B4  = 32'h1 << 4;
  localparam logic [DEPTH-1:0] B6  = 32'h1 << 6;
  localparam logic [DEPTH-1:0] B10 = 32'h1 << 10;
  localparam logic [DEPTH-1:0] B11 = 32'h1 << 11;

  initial begin
    logic m_last;
    logic hold0, hold1, nz0, nz1, g0, g1, e0, e1;

    //          rst v0 a0 d0     v1 a1 d1     rv ra  r0 r1  we wa wd     busy
    vecs.push_back(mk(1, 1, 5, 'hAA, 1, 7, 'hBB, 1, 4,  0, 0,  0, 0, 'h0,  '0));       // reset discards all
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  0, 0, 'h0,  '0));       // idle after reset
    vecs.push_back(mk(0, 1, 5, 'hAA, 0, 0, 'h0,  0, 0,  1, 0,  0, 0, 'h0,  '0));       // lone req0
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  1, 5, 'hAA, '0));       // write N+1
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  0, 5, 'hAA, '0));       // N+2: idle, hold
    vecs.push_back(mk(1, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  0, 5, 'hAA, '0));       // reset again
    vecs.push_back(mk(0, 1, 3, 'h33, 1, 7, 'h77, 0, 0,  1, 0,  0, 0, 'h0,  '0));       // conflict: req0
    vecs.push_back(mk(0, 1, 3, 'h34, 1, 7, 'h77, 0, 0,  0, 1,  1, 3, 'h33, '0));       // conflict: req1
    vecs.push_back(mk(0, 1, 3, 'h34, 1, 7, 'h78, 0, 0,  1, 0,  1, 7, 'h77, '0));       // conflict: req0
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  1, 3, 'h34, '0));
    vecs.push_back(mk(0, 1, 0, 'h11, 1, 9, 'h99, 0, 0,  1, 1,  0, 3, 'h34, '0));       // addr0 + addr9
    vecs.push_back(mk(0, 1, 1, 'h01, 1, 2, 'h02, 0, 0,  1, 0,  1, 9, 'h99, '0));       // last=req1 -> req0
    vecs.push_back(mk(0, 0, 0, 'h0,  1, 2, 'h02, 0, 0,  0, 1,  1, 1, 'h01, '0));
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  1, 2, 'h02, '0));
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  1, 4,  0, 0,  0, 2, 'h02, '0));       // rsv 4
    vecs.push_back(mk(0, 1, 4, 'h44, 0, 0, 'h0,  1, 4,  1, 0,  0, 2, 'h02, B4));       // grant 4 + rsv 4
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  1, 4, 'h44, B4));       // reserve won
    vecs.push_back(mk(0, 0, 0, 'h0,  1, 4, 'h45, 0, 0,  0, 1,  0, 4, 'h44, B4));       // lone grant 4
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  1, 0,  0, 0,  1, 4, 'h45, '0));       // cleared; rsv 0
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  1, 10, 0, 0,  0, 4, 'h45, '0));       // rsv 0 ignored
    vecs.push_back(mk(0, 1, 10,'hA0, 0, 0, 'h0,  1, 11, 1, 0,  0, 4, 'h45, B10));      // grant 10 + rsv 11
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  1, 6,  0, 0,  1, 10,'hA0, B11));      // both applied
    vecs.push_back(mk(0, 0, 0, 'h0,  1, 6, 'h66, 0, 0,  0, 1,  0, 10,'hA0, B11 | B6)); // grant 6
    vecs.push_back(mk(1, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  0, 6, 'h66, B11));      // rst squashes write
    vecs.push_back(mk(0, 0, 0, 'h0,  0, 0, 'h0,  0, 0,  0, 0,  0, 0, 'h0,  '0));       // all cleared

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_addr = vecs[i].a0; req0_data = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_addr = vecs[i].a1; req1_data = vecs[i].d1;
      rsv_valid  = vecs[i].rv; rsv_addr  = vecs[i].ra;
      #1;
      chk($sformatf("v%0d_rdy0", i),  64'(req0_ready),   64'(vecs[i].e_r0));
      chk($sformatf("v%0d_rdy1", i),  64'(req1_ready),   64'(vecs[i].e_r1));
      chk($sformatf("v%0d_we", i),    64'(rf_writeEn),   64'(vecs[i].e_we));
      chk($sformatf("v%0d_waddr", i), 64'(rf_addressw),  64'(vecs[i].e_wa));
      chk($sformatf("v%0d_wdata", i), 64'(rf_writeData), 64'(vecs[i].e_wd));
      chk($sformatf("v%0d_busy", i),  64'(busy),         64'(vecs[i].e_busy));
    end

    // Randomized contention; losers hold their request until accepted.
    m_last = 1'b1;
    hold0  = 1'b0;
    hold1  = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      rst = 1'b0;
      rsv_valid = 1'b0;
      if (!hold0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_addr  = AW'($urandom_range(0, 7));
        req0_data  = {$urandom, $urandom};
      end
      if (!hold1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_addr  = AW'($urandom_range(0, 7));
        req1_data  = {$urandom, $urandom};
      end
      #1;
      chk_write_port("rnd");
      nz0 = req0_valid && (req0_addr != 0);
      nz1 = req1_valid && (req1_addr != 0);
      g0  = nz0 && (!nz1 || m_last);
      g1  = nz1 && (!nz0 || !m_last);
      e0  = req0_valid && (!nz0 || g0);
      e1  = req1_valid && (!nz1 || g1);
      chk("rnd_rdy0", 64'(req0_ready), 64'(e0));
      chk("rnd_rdy1", 64'(req1_ready), 64'(e1));
      if (g0) begin
        sb.push_back('{a: req0_addr, d: req0_data});
        m_last = 1'b0;
      end
      if (g1) begin
        sb.push_back('{a: req1_addr, d: req1_data});
        m_last = 1'b1;
      end
      hold0 = req0_valid && !e0;
      hold1 = req1_valid && !e1;
    end

    // Drain the last pending write.
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk_write_port("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
